i2cmb_wb_writer: RTL and testbench
==================================

I2CMB_WB_WRITER -- requirements
Module: i2cmb_wb_writer

Interface
REQ-001 Parameter WB_ADDR_WIDTH, default 2, Wishbone address width.
REQ-002 Parameter WB_DATA_WIDTH, default 8, Wishbone data width.
REQ-003 Parameter IRQ_TIMEOUT, default 65535, maximum cycles to wait for irq_i per command.
REQ-004 The block SHALL have one clock, clk_i; reset is asynchronous and active-low, rst_n_i.
REQ-005 The ports SHALL be as follows:
- clk_i  in  1  clock
- rst_n_i  in  1  async active-low reset
- req_valid_i  in  1  write request valid
- req_ready_o  out  1  block idle, accepts request
- req_bus_i  in  4  I2C bus ID
- req_addr_i  in  7  I2C slave address
- req_data_i  in  8  data byte
- done_o  out  1  one-cycle completion pulse
- status_o  out  3  0=OK, 1=NAK, 2=ARB_LOST, 3=ERR, 4=TIMEOUT; held until next done_o
- cyc_o, stb_o, we_o  out  1 each  Wishbone master controls
- adr_o  out  WB_ADDR_WIDTH  register offset
- dat_o  out  WB_DATA_WIDTH  write data
- dat_i  in  WB_DATA_WIDTH  read data
- ack_i  in  1  Wishbone acknowledge
- irq_i  in  1  controller interrupt

Function
REQ-006 Register offsets SHALL be CSR=0, DPR=1, CMDR=2; command codes SHALL be WRITE=1, START=4, STOP=5, SET_BUS=6.
REQ-007 After reset, the block SHALL write CSR=0xC0 (enable, irq enable) before first asserting req_ready_o.
REQ-008 A Wishbone cycle SHALL assert cyc_o and stb_o with adr_o, dat_o and we_o stable; it SHALL hold them until the clock edge sampling ack_i=1, then deassert all of them in the next cycle.
REQ-009 req_ready_o SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid_i and req_ready_o both 1, and its fields are registered then.
REQ-010 The transaction sequence SHALL be:
- DPR=bus, CMDR=SET_BUS
- CMDR=START
- DPR={addr,1'b0}, CMDR=WRITE
- DPR=data, CMDR=WRITE
- CMDR=STOP
REQ-011 After each CMDR write, the block SHALL wait for irq_i=1, then read CMDR; the read clears the irq. Status bits are DON=bit7, NAK=bit6, AL=bit5, ERR=bit4.
REQ-012 If NAK is set after an address or data WRITE, the block SHALL skip the remaining steps, issue STOP, and report NAK.
REQ-013 AL set SHALL abort the transaction without STOP and report ARB_LOST; ERR set SHALL abort without STOP and report ERR.
REQ-014 The watchdog counter SHALL reset to 0 at each CMDR write and increment while waiting; reaching IRQ_TIMEOUT SHALL abort without STOP and report TIMEOUT.
REQ-015 If more than one status bit is set, priority SHALL be ERR > AL > NAK.
REQ-016 done_o SHALL pulse exactly one cycle after the final CMDR read, or after the timeout, and the block SHALL return to IDLE in the same cycle.
REQ-017 req_valid_i seen while busy SHALL be ignored; an irq_i asserted outside a wait state SHALL be ignored.
REQ-018 The states SHALL be INIT, IDLE, WB_WR, WB_RD, WAIT_IRQ, CHECK, DONE; the step index SHALL select adr_o/dat_o for the next step.

Reset
REQ-019 On rst_n_i=0, all outputs SHALL be 0, status_o=0, the state SHALL be INIT and the watchdog SHALL be 0, asynchronously.
REQ-020 Reset during an active Wishbone cycle SHALL drop cyc_o/stb_o immediately, with no done_o pulse; CSR init SHALL be repeated after release.

Structure
REQ-021 The register offset enum, CMDR command enum, status enum and CMDR bit positions SHALL live in the shared i2cmb package.
REQ-022 One sub-module, i2cmb_wb_port, SHALL execute a single Wishbone read or write on a start/busy/done handshake.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset release: the first Wishbone write is adr=0, dat=0xC0, and req_ready_o rises only after its ack.
- Request bus=5, addr=0x22, data=0xA5 with an ACKing slave: the CMDR writes are 6,4,1,1,5; the DPR writes are 0x05,0x44,0xA5; done_o pulses once with status=OK.
- Slave NAKs the address 0x33: the write data step is skipped, STOP is issued, and status=NAK.
- irq_i never asserts after START: done_o pulses IRQ_TIMEOUT cycles after the START CMDR write ack, with status=TIMEOUT.
- CMDR readback 0x30 (AL+ERR): status=ERR and no STOP is written.
- rst_n_i asserted mid-cycle while stb_o=1: cyc_o and stb_o go to 0 asynchronously, and the CSR init is re-issued after release.

Source files
------------

// File: rtl/i2cmb_pkg.sv
// Shared i2cmb definitions: register offsets, CMDR commands, status codes,
// CMDR status bit positions and the writer's sequencing helpers.
package i2cmb_pkg;

  typedef enum logic [1:0] {
    REG_CSR  = 2'd0,
    REG_DPR  = 2'd1,
    REG_CMDR = 2'd2
  } reg_e;

  typedef enum logic [2:0] {
    CMD_WRITE   = 3'd1,
    CMD_START   = 3'd4,
    CMD_STOP    = 3'd5,
    CMD_SET_BUS = 3'd6
  } cmd_e;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_NAK      = 3'd1,
    ST_ARB_LOST = 3'd2,
    ST_ERR      = 3'd3,
    ST_TIMEOUT  = 3'd4
  } status_e;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WB_WR, S_WB_RD, S_WAIT_IRQ, S_CHECK, S_DONE
  } state_e;

  typedef enum logic [3:0] {
    STEP_CSR, STEP_BUS_DPR, STEP_BUS_CMD, STEP_START, STEP_ADDR_DPR,
    STEP_ADDR_CMD, STEP_DATA_DPR, STEP_DATA_CMD, STEP_STOP
  } step_e;

  localparam int unsigned BIT_DON = 7;
  localparam int unsigned BIT_NAK = 6;
  localparam int unsigned BIT_AL  = 5;
  localparam int unsigned BIT_ERR = 4;

  localparam logic [7:0] CSR_INIT = 8'hC0;

  function automatic logic step_is_cmd(step_e s);
    return s inside {STEP_BUS_CMD, STEP_START, STEP_ADDR_CMD, STEP_DATA_CMD, STEP_STOP};
  endfunction

  function automatic reg_e step_reg(step_e s);
    case (s)
      STEP_CSR:                                    return REG_CSR;
      STEP_BUS_DPR, STEP_ADDR_DPR, STEP_DATA_DPR:  return REG_DPR;
      default:                                     return REG_CMDR;
    endcase
  endfunction

  function automatic logic [7:0] step_data(step_e s, logic [3:0] bus,
                                           logic [6:0] addr, logic [7:0] data);
    case (s)
      STEP_CSR:      return CSR_INIT;
      STEP_BUS_DPR:  return {4'b0000, bus};
      STEP_BUS_CMD:  return {5'b00000, CMD_SET_BUS};
      STEP_START:    return {5'b00000, CMD_START};
      STEP_ADDR_DPR: return {addr, 1'b0};
      STEP_ADDR_CMD: return {5'b00000, CMD_WRITE};
      STEP_DATA_DPR: return data;
      STEP_DATA_CMD: return {5'b00000, CMD_WRITE};
      default:       return {5'b00000, CMD_STOP};
    endcase
  endfunction

  function automatic step_e step_next(step_e s);
    case (s)
      STEP_BUS_DPR:  return STEP_BUS_CMD;
      STEP_BUS_CMD:  return STEP_START;
      STEP_START:    return STEP_ADDR_DPR;
      STEP_ADDR_DPR: return STEP_ADDR_CMD;
      STEP_ADDR_CMD: return STEP_DATA_DPR;
      STEP_DATA_DPR: return STEP_DATA_CMD;
      default:       return STEP_STOP;
    endcase
  endfunction

endpackage

// File: rtl/i2cmb_wb_writer_if.sv
// Wishbone master bus towards the i2cmb controller, including its irq line.
interface i2cmb_wb_writer_if #(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8
);
  logic                     cyc_o;
  logic                     stb_o;
  logic                     we_o;
  logic [WB_ADDR_WIDTH-1:0] adr_o;
  logic [WB_DATA_WIDTH-1:0] dat_o;
  logic [WB_DATA_WIDTH-1:0] dat_i;
  logic                     ack_i;
  logic                     irq_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i, irq_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i, irq_i
  );
endinterface

// File: rtl/i2cmb_wb_port.sv
// Single Wishbone read or write: start launches it, done marks the ack edge,
// and all bus controls drop in the cycle after that edge.
module i2cmb_wb_port #(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     start_i,
  input  logic                     we_i,
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DATA_WIDTH-1:0] wdata_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [WB_DATA_WIDTH-1:0] rdata_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i
);

  logic                     cyc_q, cyc_d;
  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;

  always_comb begin
    cyc_d = cyc_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (cyc_q) begin
      if (ack_i) begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
        adr_d = '0;
        dat_d = '0;
      end
    end else if (start_i) begin
      cyc_d = 1'b1;
      we_d  = we_i;
      adr_d = adr_i;
      dat_d = we_i ? wdata_i : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  assign cyc_o   = cyc_q;
  assign stb_o   = cyc_q;
  assign we_o    = we_q;
  assign adr_o   = adr_q;
  assign dat_o   = dat_q;
  assign busy_o  = cyc_q;
  assign done_o  = cyc_q & ack_i;
  assign rdata_o = dat_i;

endmodule

// File: rtl/i2cmb_wb_writer.sv
// Writes one byte to an I2C slave through an i2cmb controller: CSR init after
// reset, then SET_BUS, START, address, data, STOP with irq-driven status checks.
module i2cmb_wb_writer
  import i2cmb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8,
  parameter int IRQ_TIMEOUT   = 65535
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [3:0] req_bus_i,
  input  logic [6:0] req_addr_i,
  input  logic [7:0] req_data_i,
  output logic       done_o,
  output logic [2:0] status_o,
  i2cmb_wb_writer_if.master wb
);

  localparam int WD_W = $clog2(IRQ_TIMEOUT + 1);

  state_e          state_q, state_d;
  step_e           step_q, step_d;
  logic [3:0]      bus_q, bus_d;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      rb_q, rb_d;
  status_e         status_q, status_d;
  logic            nak_q, nak_d;

  logic                     port_start, port_we, port_busy, port_done;
  logic [WB_ADDR_WIDTH-1:0] port_adr;
  logic [WB_DATA_WIDTH-1:0] port_wdata, port_rdata;
  logic                     port_cyc, port_stb, port_we_o;
  logic [WB_ADDR_WIDTH-1:0] port_adr_o;
  logic [WB_DATA_WIDTH-1:0] port_dat_o;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    bus_d      = bus_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wd_d       = wd_q;
    rb_d       = rb_q;
    status_d   = status_q;
    nak_d      = nak_q;
    port_start = 1'b0;
    port_we    = 1'b0;
    port_adr   = '0;
    port_wdata = '0;
    case (state_q)
      S_INIT: begin
        step_d  = STEP_CSR;
        state_d = S_WB_WR;
      end
      S_IDLE: begin
        if (req_valid_i) begin
          bus_d   = req_bus_i;
          addr_d  = req_addr_i;
          data_d  = req_data_i;
          nak_d   = 1'b0;
          step_d  = STEP_BUS_DPR;
          state_d = S_WB_WR;
        end
      end
      S_WB_WR: begin
        port_start = !port_busy;
        port_we    = 1'b1;
        port_adr   = WB_ADDR_WIDTH'(step_reg(step_q));
        port_wdata = WB_DATA_WIDTH'(step_data(step_q, bus_q, addr_q, data_q));
        if (port_done) begin
          if (step_q == STEP_CSR) begin
            state_d = S_IDLE;
          end else if (step_is_cmd(step_q)) begin
            wd_d    = '0;
            state_d = S_WAIT_IRQ;
          end else begin
            step_d = step_next(step_q);
          end
        end
      end
      S_WAIT_IRQ: begin
        if (wb.irq_i) begin
          state_d = S_WB_RD;
        end else begin
          wd_d = wd_q + 1'b1;
          if (wd_d == WD_W'(IRQ_TIMEOUT)) begin
            status_d = ST_TIMEOUT;
            state_d  = S_DONE;
          end
        end
      end
      S_WB_RD: begin
        port_start = !port_busy;
        port_adr   = WB_ADDR_WIDTH'(REG_CMDR);
        if (port_done) begin
          rb_d    = 8'(port_rdata);
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // ERR beats AL beats NAK; a NAK only diverts address/data writes to STOP
        if (rb_q[BIT_ERR]) begin
          status_d = ST_ERR;
          state_d  = S_DONE;
        end else if (rb_q[BIT_AL]) begin
          status_d = ST_ARB_LOST;
          state_d  = S_DONE;
        end else if (step_q == STEP_STOP) begin
          status_d = nak_q ? ST_NAK : ST_OK;
          state_d  = S_DONE;
        end else if (rb_q[BIT_NAK] && (step_q inside {STEP_ADDR_CMD, STEP_DATA_CMD})) begin
          nak_d   = 1'b1;
          step_d  = STEP_STOP;
          state_d = S_WB_WR;
        end else begin
          step_d  = step_next(step_q);
          state_d = S_WB_WR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_INIT;
      step_q   <= STEP_CSR;
      bus_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wd_q     <= '0;
      rb_q     <= '0;
      status_q <= ST_OK;
      nak_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      bus_q    <= bus_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wd_q     <= wd_d;
      rb_q     <= rb_d;
      status_q <= status_d;
      nak_q    <= nak_d;
    end
  end

  i2cmb_wb_port #(
    .WB_ADDR_WIDTH(WB_ADDR_WIDTH),
    .WB_DATA_WIDTH(WB_DATA_WIDTH)
  ) u_port (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (port_start),
    .we_i    (port_we),
    .adr_i   (port_adr),
    .wdata_i (port_wdata),
    .busy_o  (port_busy),
    .done_o  (port_done),
    .rdata_o (port_rdata),
    .cyc_o   (port_cyc),
    .stb_o   (port_stb),
    .we_o    (port_we_o),
    .adr_o   (port_adr_o),
    .dat_o   (port_dat_o),
    .dat_i   (wb.dat_i),
    .ack_i   (wb.ack_i)
  );

  assign wb.cyc_o    = port_cyc;
  assign wb.stb_o    = port_stb;
  assign wb.we_o     = port_we_o;
  assign wb.adr_o    = port_adr_o;
  assign wb.dat_o    = port_dat_o;
  assign req_ready_o = (state_q == S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign status_o    = status_q;

endmodule

// File: tb/tb_i2cmb_wb_writer.sv
// Directed bench for i2cmb_wb_writer: a small i2cmb controller model acks every
// cycle, raises irq three cycles after each CMDR write and returns per-vector status.
module tb_i2cmb_wb_writer;

  localparam int AW  = 2;
  localparam int DW  = 8;
  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_bus = '0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       done;
  logic [2:0] status;

  i2cmb_wb_writer_if #(.WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW)) wb ();

  i2cmb_wb_writer #(
    .WB_ADDR_WIDTH(AW),
    .WB_DATA_WIDTH(DW),
    .IRQ_TIMEOUT  (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_bus_i   (req_bus),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .done_o      (done),
    .status_o    (status),
    .wb          (wb)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // controller model state
  int         cycle = 0;
  int         cmd_n = 0;
  int         bad_n = -1;
  int         no_irq_n = -1;
  logic [7:0] bad_rb = 8'h80;
  logic [7:0] rb_next = 8'h80;
  int         irq_cnt = 0;
  int         start_ack_cycle = -1;
  int         done_cnt = 0;
  logic [7:0] cmd_log[$];
  logic [7:0] dpr_log[$];
  logic [1:0] wr_adr_log[$];
  logic [7:0] wr_dat_log[$];

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  initial begin
    wb.ack_i = 1'b0;
    wb.irq_i = 1'b0;
    wb.dat_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wb.ack_i = 1'b0;
        wb.irq_i = 1'b0;
        irq_cnt  = 0;
      end else begin
        if (irq_cnt > 0) begin
          irq_cnt--;
          if (irq_cnt == 0) wb.irq_i = 1'b1;
        end
        if (wb.ack_i) begin
          wb.ack_i = 1'b0;
        end else if (wb.cyc_o && wb.stb_o) begin
          wb.ack_i = 1'b1;
          if (wb.we_o) begin
            wr_adr_log.push_back(wb.adr_o);
            wr_dat_log.push_back(wb.dat_o);
            if (wb.adr_o == 2'd1) dpr_log.push_back(wb.dat_o);
            if (wb.adr_o == 2'd2) begin
              cmd_log.push_back(wb.dat_o);
              if (wb.dat_o == 8'd4) start_ack_cycle = cycle + 1;
              rb_next = (cmd_n == bad_n) ? bad_rb : 8'h80;
              if (cmd_n != no_irq_n) irq_cnt = 3;
              cmd_n++;
            end
          end else begin
            wb.dat_i = rb_next;
            wb.irq_i = 1'b0;
          end
        end
      end
    end
  end

  typedef struct {
    logic [3:0]  bus;
    logic [6:0]  addr;
    logic [7:0]  data;
    int          bad_n;
    logic [7:0]  bad_rb;
    int          no_irq_n;
    int          exp_st;
    int          ncmd;
    logic [39:0] cmds;
    int          ndpr;
    logic [23:0] dprs;
  } vec_t;

  function automatic vec_t mk(logic [3:0] bus, logic [6:0] addr, logic [7:0] data,
                              int bad_n_i, logic [7:0] bad_rb_i, int no_irq_i, int st,
                              int ncmd, logic [39:0] cmds, int ndpr, logic [23:0] dprs);
    vec_t v;
    v.bus = bus; v.addr = addr; v.data = data;
    v.bad_n = bad_n_i; v.bad_rb = bad_rb_i; v.no_irq_n = no_irq_i;
    v.exp_st = st; v.ncmd = ncmd; v.cmds = cmds; v.ndpr = ndpr; v.dprs = dprs;
    return v;
  endfunction

  // wait for the first write after reset release and check it is the CSR init
  task automatic check_csr_init(input string tag);
    int  n = 0;
    bit  ready_early = 0;
    while (wr_adr_log.size() == 0 && n < 50) begin
      tick();
      if (req_ready) ready_early = 1;
      n++;
    end
    check({tag, "_init_seen"}, int'(wr_adr_log.size() > 0), 1);
    if (wr_adr_log.size() > 0) begin
      check({tag, "_init_adr"}, int'(wr_adr_log[0]), 0);
      check({tag, "_init_dat"}, int'(wr_dat_log[0]), 8'hC0);
    end
    check({tag, "_ready_before_ack"}, int'(ready_early), 0);
    tick();
    check({tag, "_ready_after_ack"}, int'(req_ready), 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    bit busy_ready = 0;
    string tag;
    tag = $sformatf("v%0d", idx);
    cmd_log.delete();
    dpr_log.delete();
    cmd_n = 0;
    bad_n = v.bad_n;
    bad_rb = v.bad_rb;
    no_irq_n = v.no_irq_n;
    start_ack_cycle = -1;
    n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    check({tag, "_ready"}, int'(req_ready), 1);
    done_cnt = 0;
    req_bus = v.bus; req_addr = v.addr; req_data = v.data; req_valid = 1'b1;
    tick();
    req_bus = ~v.bus; req_addr = ~v.addr; req_data = ~v.data;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (req_ready) busy_ready = 1;
    end
    req_valid = 1'b0;
    check({tag, "_ready_while_busy"}, int'(busy_ready), 0);
    n = 0;
    while (!done && n < TMO + 400) begin tick(); n++; end
    check({tag, "_done_seen"}, int'(done), 1);
    check({tag, "_status"}, int'(status), v.exp_st);
    if (v.exp_st == 4) check({tag, "_tmo_latency"}, cycle - start_ack_cycle, TMO);
    for (int i = 0; i < 5; i++) tick();
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_status_held"}, int'(status), v.exp_st);
    check({tag, "_ncmd"}, cmd_log.size(), v.ncmd);
    for (int i = 0; i < v.ncmd; i++)
      check($sformatf("%s_cmd%0d", tag, i),
            (i < cmd_log.size()) ? int'(cmd_log[i]) : -1, int'(v.cmds[39-8*i -: 8]));
    check({tag, "_ndpr"}, dpr_log.size(), v.ndpr);
    for (int i = 0; i < v.ndpr; i++)
      check($sformatf("%s_dpr%0d", tag, i),
            (i < dpr_log.size()) ? int'(dpr_log[i]) : -1, int'(v.dprs[23-8*i -: 8]));
  endtask

  vec_t vecs[9];

  initial begin
    int n;
    vecs[0] = mk(4'h5, 7'h22, 8'hA5, -1, 8'h80, -1, 0, 5, 40'h0604010105, 3, 24'h0544A5);
    vecs[1] = mk(4'h3, 7'h33, 8'h5A,  2, 8'hC0, -1, 1, 4, 40'h0604010500, 2, 24'h036600);
    vecs[2] = mk(4'h0, 7'h10, 8'hFF, -1, 8'h80,  1, 4, 2, 40'h0604000000, 1, 24'h000000);
    vecs[3] = mk(4'h1, 7'h7F, 8'h00,  2, 8'h30, -1, 3, 3, 40'h0604010000, 2, 24'h01FE00);
    vecs[4] = mk(4'hF, 7'h01, 8'h3C, -1, 8'h80, -1, 0, 5, 40'h0604010105, 3, 24'h0F023C);
    vecs[5] = mk(4'h2, 7'h45, 8'hC3,  3, 8'hC0, -1, 1, 5, 40'h0604010105, 3, 24'h028AC3);
    vecs[6] = mk(4'h6, 7'h12, 8'h34,  1, 8'hA0, -1, 2, 2, 40'h0604000000, 1, 24'h060000);
    vecs[7] = mk(4'h7, 7'h55, 8'hAA,  2, 8'h60, -1, 2, 3, 40'h0604010000, 2, 24'h07AA00);
    vecs[8] = mk(4'h8, 7'h66, 8'h11,  2, 8'h50, -1, 3, 3, 40'h0604010000, 2, 24'h08CC00);

    // reset state
    rst_n = 1'b0;
    tick(); tick();
    check("rst_cyc", int'(wb.cyc_o), 0);
    check("rst_stb", int'(wb.stb_o), 0);
    check("rst_we", int'(wb.we_o), 0);
    check("rst_adr", int'(wb.adr_o), 0);
    check("rst_dat", int'(wb.dat_o), 0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_status", int'(status), 0);
    wr_adr_log.delete(); wr_dat_log.delete();
    rst_n = 1'b1;
    check_csr_init("boot");

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // reset in the middle of a Wishbone cycle
    n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    done_cnt = 0;
    req_bus = 4'h5; req_addr = 7'h22; req_data = 8'hA5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!wb.stb_o && n < 50) begin @(posedge clk); #1; n++; end
    check("mid_stb_seen", int'(wb.stb_o), 1);
    rst_n = 1'b0;
    #1;
    check("mid_cyc_async", int'(wb.cyc_o), 0);
    check("mid_stb_async", int'(wb.stb_o), 0);
    tick(); tick(); tick();
    check("mid_no_done", done_cnt, 0);
    check("mid_status", int'(status), 0);
    wr_adr_log.delete(); wr_dat_log.delete();
    rst_n = 1'b1;
    check_csr_init("mid");
    run_vec(vecs[0], 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule
